// File: rtl/sparse_pkg.sv
// Shared types and default dimensions for the streaming COO sparse matrix multiplier.
package sparse_pkg;

  localparam int DATA_SIZE     = 16;
  localparam int M             = 4;
  localparam int N             = 4;
  localparam int K             = 4;
  localparam int MAX_LIST_SIZE = 30;
  localparam int MAX_DIM       = (M > N) ? ((M > K) ? M : K) : ((N > K) ? N : K);
  // One spare index bit keeps out-of-range coordinates representable so they can be flagged.
  localparam int IDX_W         = $clog2(MAX_DIM + 1);
  localparam int ACC_SIZE      = 2 * DATA_SIZE + $clog2(N + 1);

  typedef struct packed {
    logic [IDX_W-1:0]            row;
    logic [IDX_W-1:0]            col;
    logic signed [DATA_SIZE-1:0] val;
  } entry;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_t;

endpackage

// File: rtl/coo_list_buf.sv
// Entry store for one COO list: append-only writes, occupancy count, full flag, random read.
module coo_list_buf
  import sparse_pkg::*;
#(
  parameter int DEPTH = MAX_LIST_SIZE,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  entry             i_wr_data,
  input  logic [CNT_W-1:0] i_rd_addr,
  output entry             o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  entry             r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = r_mem[i_rd_addr];

  always_ff @(posedge clk) begin
    if (i_wr_en && !o_full) begin
      r_mem[r_count] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_wr_en && !o_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sparse_coo_mm_stream.sv
// Streaming C = A*B from two buffered COO lists: one MAC per cycle over all (A,B) pairs,
// then a row-major dense drain of C over a valid/ready port.
module sparse_coo_mm_stream
  import sparse_pkg::*;
#(
  parameter int DATA_SIZE     = sparse_pkg::DATA_SIZE,
  parameter int M             = sparse_pkg::M,
  parameter int N             = sparse_pkg::N,
  parameter int K             = sparse_pkg::K,
  parameter int MAX_LIST_SIZE = sparse_pkg::MAX_LIST_SIZE,
  parameter int ACC_SIZE      = 2 * DATA_SIZE + $clog2(N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  entry                       in_entry,
  input  logic                       in_is_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_SIZE-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       err_overflow,
  output logic                       err_index
);

  localparam int CNT_W  = $clog2(MAX_LIST_SIZE + 1);
  localparam int C_NUM  = M * K;
  localparam int C_W    = (C_NUM > 1) ? $clog2(C_NUM) : 1;
  localparam int PROD_W = 2 * DATA_SIZE;

  state_t                     r_state, w_state_next;
  logic                       w_load_a, w_load_b, w_accept, w_wrong_list, w_idx_ok;
  logic                       w_a_full, w_b_full, w_a_wr, w_b_wr;
  logic [CNT_W-1:0]           w_a_cnt, w_b_cnt, r_ia, r_ib;
  entry                       w_a_rd, w_b_rd;
  logic                       r_err_overflow, r_err_index;
  logic [C_W-1:0]             r_out_idx, w_c_idx;
  logic                       w_cmp_empty, w_cmp_done, w_mac_en;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_SIZE-1:0] w_prod_ext;
  logic signed [ACC_SIZE-1:0] w_c [C_NUM];

  assign w_load_a     = (r_state == LOAD_A);
  assign w_load_b     = (r_state == LOAD_B);
  assign w_accept     = in_valid && (w_load_a || w_load_b);
  assign w_wrong_list = w_load_a ? in_is_b : !in_is_b;

  always_comb begin
    w_idx_ok = 1'b0;
    if (w_load_a) begin
      w_idx_ok = (in_entry.row < IDX_W'(M)) && (in_entry.col < IDX_W'(N));
    end else begin
      w_idx_ok = (in_entry.row < IDX_W'(N)) && (in_entry.col < IDX_W'(K));
    end
  end

  assign w_a_wr = w_accept && w_load_a && !w_wrong_list && w_idx_ok && !w_a_full;
  assign w_b_wr = w_accept && w_load_b && !w_wrong_list && w_idx_ok && !w_b_full;

  coo_list_buf #(.DEPTH(MAX_LIST_SIZE)) u_a_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == IDLE),
    .i_wr_en   (w_a_wr),
    .i_wr_data (in_entry),
    .i_rd_addr (r_ia),
    .o_rd_data (w_a_rd),
    .o_count   (w_a_cnt),
    .o_full    (w_a_full)
  );

  coo_list_buf #(.DEPTH(MAX_LIST_SIZE)) u_b_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == IDLE),
    .i_wr_en   (w_b_wr),
    .i_wr_data (in_entry),
    .i_rd_addr (r_ib),
    .o_rd_data (w_b_rd),
    .o_count   (w_b_cnt),
    .o_full    (w_b_full)
  );

  // An empty list still spends exactly one COMPUTE cycle before draining.
  assign w_cmp_empty = (w_a_cnt == '0) || (w_b_cnt == '0);
  assign w_cmp_done  = w_cmp_empty ||
                       ((r_ia == w_a_cnt - 1'b1) && (r_ib == w_b_cnt - 1'b1));
  assign w_mac_en    = (r_state == COMPUTE) && !w_cmp_empty && (w_a_rd.col == w_b_rd.row);
  assign w_prod      = $signed(w_a_rd.val) * $signed(w_b_rd.val);
  assign w_prod_ext  = {{(ACC_SIZE - PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_c_idx     = C_W'(w_a_rd.row) * C_W'(K) + C_W'(w_b_rd.col);

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM; gi++) begin : g_acc
      logic signed [ACC_SIZE-1:0] r_acc;
      always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
          r_acc <= '0;
        end else if (w_mac_en && w_c_idx == C_W'(gi)) begin
          r_acc <= r_acc + w_prod_ext;
        end
      end
      assign w_c[gi] = r_acc;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    case (r_state)
      IDLE:    w_state_next = LOAD_A;
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_next = COMPUTE;
      end
      COMPUTE: if (w_cmp_done) w_state_next = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (r_out_idx == C_W'(C_NUM - 1));
        if (out_ready && out_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ia           <= '0;
      r_ib           <= '0;
      r_out_idx      <= '0;
      r_err_index    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_accept && (w_wrong_list || !w_idx_ok)) begin
        r_err_index <= 1'b1;
      end
      if (w_accept && !w_wrong_list && (w_load_a ? w_a_full : w_b_full)) begin
        r_err_overflow <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_ia      <= '0;
          r_ib      <= '0;
          r_out_idx <= '0;
        end
        COMPUTE: begin
          if (w_cmp_done) begin
            r_ia <= '0;
            r_ib <= '0;
          end else if (r_ib == w_b_cnt - 1'b1) begin
            r_ib <= '0;
            r_ia <= r_ia + 1'b1;
          end else begin
            r_ib <= r_ib + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) r_out_idx <= r_out_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data     = w_c[r_out_idx];
  assign busy         = (r_state != IDLE);
  assign err_overflow = r_err_overflow;
  assign err_index    = r_err_index;

endmodule
